ex_stage: RTL and testbench
===========================

Name: ex_stage

Overview:
- Execute stage of the 5-stage MIPS pipeline. It sits between the ID/EX operand latch and the memory stage.
- Performs single-cycle ALU operations.
- Contains an iterative 32-cycle unsigned multiplier with HI/LO registers and a hazard stall output.
- Registers all results into the EX/MEM boundary: ALUOutM, WriteDataM, WriteRegM, MemWriteM, MemtoRegM and RegWriteM, which feed the memory stage directly.

Parameters:
- WIDTH, 32, datapath width; only 32 is supported.
- MUL_CYCLES, 32, number of BUSY iterations per MULTU; must equal WIDTH.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  reset; synchronous, active-high.
- ValidE  in  1  the EX slot holds a real instruction (0 = bubble).
- SrcAE  in  32  operand A (rs).
- SrcBE  in  32  operand B (rt or sign-extended immediate).
- WriteDataE  in  32  store data (rt).
- WriteRegE  in  5  destination register.
- ALUControlE  in  4  operation select.
- RegWriteE  in  1  instruction writes a GPR.
- MemtoRegE  in  1  load instruction.
- MemWriteE  in  1  store instruction.
- StallE  out  1  hold the EX slot and all upstream stages this cycle.
- MulBusy  out  1  multiplier is iterating.
- ALUOutM  out  32  registered ALU result or memory address.
- WriteDataM  out  32  registered store data.
- WriteRegM  out  5  registered destination register.
- RegWriteM  out  1  registered GPR write enable.
- MemtoRegM  out  1  registered load flag.
- MemWriteM  out  1  registered store enable.

Behaviour:
- Reset: synchronous, active-high.
  - All M outputs, HI, LO, the counter and the multiplier accumulator clear to 0.
  - State goes to IDLE; StallE and MulBusy are 0 from the first cycle after reset.
  - Reset while BUSY aborts the multiply; HI/LO are 0 afterwards.
- ALUControlE encoding:
  - 0000 AND; 0001 OR; 0010 ADD; 0110 SUB.
  - 0111 SLT: signed compare, result 1 or 0.
  - 1100 NOR.
  - 1000 MULTU; 1001 MFHI; 1010 MFLO.
  - Any other code gives a result of 0.
- Arithmetic: ADD and SUB are modulo 2^32 with no trap unless the optional feature is compiled in.
- Latency: one cycle. An accepted instruction in EX at edge t appears on the M outputs after edge t.
- Bubble rule: when ValidE=0 or StallE=1, the next M-output values are RegWriteM=0 and MemWriteM=0. The other M fields are don't-care, driven as 0.
- MULTU in IDLE with ValidE=1:
  - Latch SrcAE and SrcBE, clear the accumulator, set counter=MUL_CYCLES, go to BUSY.
  - MULTU writes no GPR, so it retires as a bubble into M.
- BUSY, one shift-add step per cycle:
  - If the multiplier LSB is 1, add the multiplicand into the upper half of the 64-bit accumulator.
  - Shift the accumulator right by 1 and decrement the counter.
  - On the edge where the counter goes 1→0, write HI/LO with the 64-bit product and return to IDLE.
  - MulBusy = (state==BUSY).
- StallE (combinational) = BUSY && ValidE && ALUControlE is MULTU, MFHI or MFLO.
  - Upstream holds every E input stable while StallE=1.
  - Other instructions proceed normally during BUSY, overlapping with the multiply.
- Timing: with MULTU accepted at edge t0, HI/LO are valid after edge t0+32. A dependent MFLO in E in the cycle after t0 sees StallE=1 for 32 cycles and is accepted at edge t0+33.
- MFHI/MFLO in IDLE: ALUOutM = HI or LO, RegWriteM = RegWriteE.
- WriteDataM, WriteRegM, MemtoRegM and MemWriteM pass through the stage registered.

Optional Feature:
- EX_OVERFLOW_EN defined:
  - ADD/SUB detect signed overflow: operands of equal sign (ADD) or opposite sign (SUB) whose result sign differs from A.
  - On overflow, RegWriteM is forced to 0 and a registered output OverflowM (1 bit, reset 0) pulses high for one cycle.
- EX_OVERFLOW_EN undefined: OverflowM is absent and ADD/SUB always write.

Test Plan:
- ADD, 0x00000005 + 0xFFFFFFFD, WriteRegE=3, RegWriteE=1 → next cycle ALUOutM=0x00000002, WriteRegM=3, RegWriteM=1.
- SLT with A=0xFFFFFFFF, B=0x00000001 → ALUOutM=1. SUB 0x10-0x20 → ALUOutM=0xFFFFFFF0.
- MULTU A=B=0xFFFFFFFF, then MFHI and MFLO in successive slots:
  - StallE=1 for exactly 32 cycles.
  - Then ALUOutM=0xFFFFFFFE followed by 0x00000001.
  - No RegWriteM during the stall.
- MULTU 3×7 followed by an independent ADD and a store (MemWriteE=1) → both pass with StallE=0 while MulBusy=1; a later MFLO returns 0x00000015.
- rst=1 asserted 10 cycles into a MULTU:
  - The next cycle shows MulBusy=0 and all M outputs 0.
  - A following MFLO returns 0 with no stall.
- EX_OVERFLOW_EN defined, ADD 0x7FFFFFFF+1 → RegWriteM=0 and OverflowM=1 for one cycle.
- EX_OVERFLOW_EN undefined, same ADD → RegWriteM=1 and ALUOutM=0x80000000.

Source files
------------

// File: rtl/ex_stage.sv
// MIPS execute stage: single-cycle ALU, iterative 32-step MULTU with HI/LO, EX/MEM output registers.
// Optional signed-overflow trap on ADD/SUB is enabled by defining EX_OVERFLOW_EN (adds OverflowM).
module ex_stage #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned MUL_CYCLES = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ValidE,
  input  logic [WIDTH-1:0] SrcAE,
  input  logic [WIDTH-1:0] SrcBE,
  input  logic [WIDTH-1:0] WriteDataE,
  input  logic [4:0]       WriteRegE,
  input  logic [3:0]       ALUControlE,
  input  logic             RegWriteE,
  input  logic             MemtoRegE,
  input  logic             MemWriteE,
  output logic             StallE,
  output logic             MulBusy,
  output logic [WIDTH-1:0] ALUOutM,
  output logic [WIDTH-1:0] WriteDataM,
  output logic [4:0]       WriteRegM,
  output logic             RegWriteM,
  output logic             MemtoRegM,
`ifdef EX_OVERFLOW_EN
  output logic             OverflowM,
`endif
  output logic             MemWriteM
);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_NOR  = 4'b1100;
  localparam logic [3:0] OP_MULT = 4'b1000;
  localparam logic [3:0] OP_MFHI = 4'b1001;
  localparam logic [3:0] OP_MFLO = 4'b1010;
  localparam int unsigned CW = $clog2(MUL_CYCLES + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t             state, state_next;
  logic [CW-1:0]      count;
  logic [WIDTH-1:0]   mcand, mplier, hi, lo;
  logic [2*WIDTH-1:0] acc, acc_next;
  logic [WIDTH:0]     step_sum;
  logic [WIDTH-1:0]   result, sum, diff;
  logic               mul_op, is_mult, accept, start, ovf;

  assign sum     = SrcAE + SrcBE;
  assign diff    = SrcAE - SrcBE;
  assign is_mult = (ALUControlE == OP_MULT);
  assign mul_op  = is_mult || (ALUControlE == OP_MFHI) || (ALUControlE == OP_MFLO);
  assign MulBusy = (state == BUSY);
  assign StallE  = MulBusy && ValidE && mul_op;
  assign accept  = ValidE && !StallE;
  assign start   = (state == IDLE) && ValidE && is_mult;

  // Carry out of the upper-half add lands in the MSB after the right shift.
  assign step_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (mplier[0] ? {1'b0, mcand} : '0);
  assign acc_next = {step_sum, acc[WIDTH-1:1]};

`ifdef EX_OVERFLOW_EN
  always_comb begin
    ovf = 1'b0;
    if (ALUControlE == OP_ADD)
      ovf = (SrcAE[WIDTH-1] == SrcBE[WIDTH-1]) && (sum[WIDTH-1] != SrcAE[WIDTH-1]);
    else if (ALUControlE == OP_SUB)
      ovf = (SrcAE[WIDTH-1] != SrcBE[WIDTH-1]) && (diff[WIDTH-1] != SrcAE[WIDTH-1]);
  end
`else
  assign ovf = 1'b0;
`endif

  always_comb begin
    result = '0;
    case (ALUControlE)
      OP_AND:  result = SrcAE & SrcBE;
      OP_OR:   result = SrcAE | SrcBE;
      OP_ADD:  result = sum;
      OP_SUB:  result = diff;
      OP_SLT:  result = {{(WIDTH-1){1'b0}}, ($signed(SrcAE) < $signed(SrcBE))};
      OP_NOR:  result = ~(SrcAE | SrcBE);
      OP_MFHI: result = hi;
      OP_MFLO: result = lo;
      default: result = '0;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = BUSY;
      BUSY:    if (count == CW'(1)) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      count  <= '0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE) begin
        if (start) begin
          mcand  <= SrcAE;
          mplier <= SrcBE;
          acc    <= '0;
          count  <= CW'(MUL_CYCLES);
        end
      end else begin
        acc    <= acc_next;
        mplier <= mplier >> 1;
        count  <= count - CW'(1);
        if (count == CW'(1)) begin
          hi <= acc_next[2*WIDTH-1:WIDTH];
          lo <= acc_next[WIDTH-1:0];
        end
      end
    end
  end

  // MULTU writes no GPR, so it retires into M exactly like a bubble.
  always_ff @(posedge clk) begin
    if (rst || !accept || is_mult) begin
      ALUOutM    <= '0;
      WriteDataM <= '0;
      WriteRegM  <= '0;
      RegWriteM  <= 1'b0;
      MemtoRegM  <= 1'b0;
      MemWriteM  <= 1'b0;
`ifdef EX_OVERFLOW_EN
      OverflowM  <= 1'b0;
`endif
    end else begin
      ALUOutM    <= result;
      WriteDataM <= WriteDataE;
      WriteRegM  <= WriteRegE;
      RegWriteM  <= RegWriteE && !ovf;
      MemtoRegM  <= MemtoRegE;
      MemWriteM  <= MemWriteE;
`ifdef EX_OVERFLOW_EN
      OverflowM  <= ovf;
`endif
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Directed self-checking bench for ex_stage: ALU ops, bubbles, MULTU stall timing, reset abort, overflow.
module tb_ex_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        ValidE;
  logic [31:0] SrcAE, SrcBE, WriteDataE;
  logic [4:0]  WriteRegE;
  logic [3:0]  ALUControlE;
  logic        RegWriteE, MemtoRegE, MemWriteE;
  logic        StallE, MulBusy;
  logic [31:0] ALUOutM, WriteDataM;
  logic [4:0]  WriteRegM;
  logic        RegWriteM, MemtoRegM, MemWriteM;
`ifdef EX_OVERFLOW_EN
  logic        OverflowM;
`endif

  int errors = 0;
  int checks = 0;
  int stalls;

  always #5 clk = ~clk;

  ex_stage #(.WIDTH(32), .MUL_CYCLES(32)) dut (
    .clk(clk), .rst(rst), .ValidE(ValidE), .SrcAE(SrcAE), .SrcBE(SrcBE),
    .WriteDataE(WriteDataE), .WriteRegE(WriteRegE), .ALUControlE(ALUControlE),
    .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .MemWriteE(MemWriteE),
    .StallE(StallE), .MulBusy(MulBusy), .ALUOutM(ALUOutM), .WriteDataM(WriteDataM),
    .WriteRegM(WriteRegM), .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM),
`ifdef EX_OVERFLOW_EN
    .OverflowM(OverflowM),
`endif
    .MemWriteM(MemWriteM)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drv(input logic v, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] wd, input logic [4:0] wr, input logic rw, input logic mtr,
                     input logic mw);
    ValidE = v; ALUControlE = op; SrcAE = a; SrcBE = b; WriteDataE = wd;
    WriteRegE = wr; RegWriteE = rw; MemtoRegE = mtr; MemWriteE = mw;
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    drv(1, 4'b0010, 32'h1, 32'h1, 32'h1234, 5'd7, 1, 1, 1);
    tick; tick;
    chk("rst_aluout", ALUOutM, 32'h0);
    chk("rst_regwrite", {31'b0, RegWriteM}, 32'h0);
    chk("rst_memwrite", {31'b0, MemWriteM}, 32'h0);
    chk("rst_mulbusy", {31'b0, MulBusy}, 32'h0);
    rst = 1'b0;

    drv(1, 4'b0010, 32'h5, 32'hFFFFFFFD, 32'h0, 5'd3, 1, 0, 0);
    tick;
    chk("add_out", ALUOutM, 32'h2);
    chk("add_wreg", {27'b0, WriteRegM}, 32'd3);
    chk("add_rw", {31'b0, RegWriteM}, 32'h1);

    drv(1, 4'b0111, 32'hFFFFFFFF, 32'h1, 32'h0, 5'd4, 1, 0, 0);
    tick;
    chk("slt_out", ALUOutM, 32'h1);
    drv(1, 4'b0110, 32'h10, 32'h20, 32'h0, 5'd4, 1, 0, 0);
    tick;
    chk("sub_out", ALUOutM, 32'hFFFFFFF0);
    drv(1, 4'b0000, 32'hFF00FF00, 32'h0FF00FF0, 32'h0, 5'd4, 1, 0, 0);
    tick;
    chk("and_out", ALUOutM, 32'h0F000F00);
    drv(1, 4'b0001, 32'hF0, 32'h0F, 32'h0, 5'd4, 1, 0, 0);
    tick;
    chk("or_out", ALUOutM, 32'hFF);
    drv(1, 4'b1100, 32'h0000FFFF, 32'h00FF0000, 32'h0, 5'd4, 1, 0, 0);
    tick;
    chk("nor_out", ALUOutM, 32'hFF000000);
    drv(1, 4'b0011, 32'h12, 32'h34, 32'h0, 5'd9, 1, 0, 0);
    tick;
    chk("undef_out", ALUOutM, 32'h0);
    chk("undef_rw", {31'b0, RegWriteM}, 32'h1);

    drv(0, 4'b0010, 32'h1, 32'h2, 32'hAA, 5'd6, 1, 0, 1);
    tick;
    chk("bubble_rw", {31'b0, RegWriteM}, 32'h0);
    chk("bubble_mw", {31'b0, MemWriteM}, 32'h0);

    drv(1, 4'b0010, 32'h100, 32'h8, 32'hDEADBEEF, 5'd2, 0, 0, 1);
    tick;
    chk("st_addr", ALUOutM, 32'h108);
    chk("st_wdata", WriteDataM, 32'hDEADBEEF);
    chk("st_mw", {31'b0, MemWriteM}, 32'h1);
    drv(1, 4'b0010, 32'h200, 32'h4, 32'h0, 5'd12, 1, 1, 0);
    tick;
    chk("ld_mtr", {31'b0, MemtoRegM}, 32'h1);
    chk("ld_wreg", {27'b0, WriteRegM}, 32'd12);

    // MULTU 0xFFFFFFFF^2 followed by dependent MFHI/MFLO
    drv(1, 4'b1000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 5'd1, 1, 0, 0);
    tick;
    chk("mult_busy", {31'b0, MulBusy}, 32'h1);
    chk("mult_rw", {31'b0, RegWriteM}, 32'h0);
    drv(1, 4'b1001, 32'h0, 32'h0, 32'h0, 5'd5, 1, 0, 0);
    stalls = 0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (!StallE) break;
      stalls++;
      tick;
      if (RegWriteM !== 1'b0) chk("stall_rw", {31'b0, RegWriteM}, 32'h0);
    end
    chk("stall_count", stalls, 32'd32);
    tick;
    chk("mfhi_out", ALUOutM, 32'hFFFFFFFE);
    chk("mfhi_rw", {31'b0, RegWriteM}, 32'h1);
    chk("mfhi_wreg", {27'b0, WriteRegM}, 32'd5);
    drv(1, 4'b1010, 32'h0, 32'h0, 32'h0, 5'd6, 1, 0, 0);
    #1 chk("mflo_nostall", {31'b0, StallE}, 32'h0);
    tick;
    chk("mflo_out", ALUOutM, 32'h00000001);

    // MULTU 3x7 overlapped with independent ops
    drv(1, 4'b1000, 32'h3, 32'h7, 32'h0, 5'd0, 0, 0, 0);
    tick;
    drv(1, 4'b0010, 32'h1, 32'h2, 32'h0, 5'd4, 1, 0, 0);
    #1 chk("ovl_add_stall", {31'b0, StallE}, 32'h0);
    chk("ovl_add_busy", {31'b0, MulBusy}, 32'h1);
    tick;
    chk("ovl_add_out", ALUOutM, 32'h3);
    chk("ovl_add_rw", {31'b0, RegWriteM}, 32'h1);
    drv(1, 4'b0010, 32'h100, 32'h4, 32'h55, 5'd0, 0, 0, 1);
    #1 chk("ovl_st_stall", {31'b0, StallE}, 32'h0);
    tick;
    chk("ovl_st_mw", {31'b0, MemWriteM}, 32'h1);
    chk("ovl_st_wdata", WriteDataM, 32'h55);
    drv(1, 4'b1010, 32'h0, 32'h0, 32'h0, 5'd8, 1, 0, 0);
    for (int i = 0; i < 40; i++) begin
      #1;
      if (!StallE) break;
      tick;
    end
    chk("mul37_stall_end", {31'b0, StallE}, 32'h0);
    tick;
    chk("mul37_lo", ALUOutM, 32'h15);
    drv(1, 4'b1001, 32'h0, 32'h0, 32'h0, 5'd8, 1, 0, 0);
    tick;
    chk("mul37_hi", ALUOutM, 32'h0);

    // Reset during a multiply aborts it and clears HI/LO
    drv(1, 4'b1000, 32'hFFFF, 32'hFFFF, 32'h0, 5'd0, 0, 0, 0);
    tick;
    drv(0, 4'b0000, 32'h0, 32'h0, 32'h0, 5'd0, 0, 0, 0);
    for (int i = 0; i < 9; i++) tick;
    chk("pre_rst_busy", {31'b0, MulBusy}, 32'h1);
    rst = 1'b1;
    drv(1, 4'b0010, 32'h7, 32'h7, 32'h99, 5'd3, 1, 1, 1);
    tick;
    rst = 1'b0;
    chk("abort_busy", {31'b0, MulBusy}, 32'h0);
    chk("abort_aluout", ALUOutM, 32'h0);
    chk("abort_wdata", WriteDataM, 32'h0);
    chk("abort_rw", {31'b0, RegWriteM}, 32'h0);
    chk("abort_mtr", {31'b0, MemtoRegM}, 32'h0);
    chk("abort_mw", {31'b0, MemWriteM}, 32'h0);
    drv(1, 4'b1010, 32'h0, 32'h0, 32'h0, 5'd10, 1, 0, 0);
    #1 chk("abort_mflo_stall", {31'b0, StallE}, 32'h0);
    tick;
    chk("abort_mflo_out", ALUOutM, 32'h0);
    chk("abort_mflo_rw", {31'b0, RegWriteM}, 32'h1);

    drv(1, 4'b0010, 32'h7FFFFFFF, 32'h1, 32'h0, 5'd11, 1, 0, 0);
    tick;
`ifdef EX_OVERFLOW_EN
    chk("ovf_rw", {31'b0, RegWriteM}, 32'h0);
    chk("ovf_flag", {31'b0, OverflowM}, 32'h1);
    drv(0, 4'b0000, 32'h0, 32'h0, 32'h0, 5'd0, 0, 0, 0);
    tick;
    chk("ovf_pulse", {31'b0, OverflowM}, 32'h0);
`else
    chk("wrap_rw", {31'b0, RegWriteM}, 32'h1);
    chk("wrap_out", ALUOutM, 32'h80000000);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
